ram_single_port_arbiter: RTL and testbench



---
 rtl/ram_single_port_arbiter_if.sv | 24 ++
 rtl/ram_single_port_arbiter.sv | 116 +++++++++++
 tb/tb_ram_single_port_arbiter.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_single_port_arbiter_if.sv
// Client request/response bundle for ram_single_port_arbiter.
// master: the requesting client; slave: the arbiter.
interface ram_single_port_arbiter_if #(
    parameter int WIDTH         = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic                     valid;
    logic                     ready;
    logic                     write;
    logic [ADDRESS_WIDTH-1:0] address;
    logic [WIDTH-1:0]         write_data;
    logic                     read_valid;
    logic [WIDTH-1:0]         read_data;

    modport master (
        output valid, write, address, write_data,
        input  ready, read_valid, read_data
    );

    modport slave (
        input  valid, write, address, write_data,
        output ready, read_valid, read_data
    );
endinterface

// File: rtl/ram_single_port_arbiter.sv
// Two-client arbiter in front of a single-port RAM with a combinational read.
// Grant is combinational; read responses are registered one cycle after acceptance.
// Optional macro RAM_SINGLE_PORT_ARBITER_ROUND_ROBIN_EN: when defined, contention
// alternates using last_grant; when undefined, client 0 has fixed priority.
module ram_single_port_arbiter #(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 16,
    parameter int ADDRESS_WIDTH = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     resetn,
    ram_single_port_arbiter_if.slave port0,
    ram_single_port_arbiter_if.slave port1,
    output logic                     ram_write_enable,
    output logic                     ram_read_enable,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [WIDTH-1:0]         ram_write_data,
    input  logic [WIDTH-1:0]         ram_read_data
);

    logic             grant0;
    logic             grant1;
    logic             read_valid0;
    logic             read_valid1;
    logic [WIDTH-1:0] read_data0;
    logic [WIDTH-1:0] read_data1;

`ifdef RAM_SINGLE_PORT_ARBITER_ROUND_ROBIN_EN
    // 1 = client 1 made the most recent transfer; reset to 1 so client 0 wins first.
    logic last_grant;

    // Round-robin grant: on contention the client that did not transfer last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (port0.valid && port1.valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = port0.valid;
            grant1 = port1.valid;
        end
    end

    // Remember the client of every transfer; hold across idle cycles.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant <= 1'b1;
        end else if (grant0) begin
            last_grant <= 1'b0;
        end else if (grant1) begin
            last_grant <= 1'b1;
        end
    end
`else
    // Fixed priority grant: client 1 only when client 0 is not requesting.
    always_comb begin
        grant0 = port0.valid;
        grant1 = port1.valid && !port0.valid;
    end
`endif

    assign port0.ready = grant0;
    assign port1.ready = grant1;

    // Steer the granted client onto the RAM port; drive zeros when idle.
    always_comb begin
        ram_write_enable = 1'b0;
        ram_read_enable  = 1'b0;
        ram_address      = '0;
        ram_write_data   = '0;
        if (grant0) begin
            ram_write_enable = port0.write;
            ram_read_enable  = !port0.write;
            ram_address      = port0.address;
            ram_write_data   = port0.write_data;
        end else if (grant1) begin
            ram_write_enable = port1.write;
            ram_read_enable  = !port1.write;
            ram_address      = port1.address;
            ram_write_data   = port1.write_data;
        end
    end

    // Client 0 read response: pulse valid and capture data on an accepted read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_valid0 <= 1'b0;
            read_data0  <= '0;
        end else begin
            read_valid0 <= grant0 && !port0.write;
            if (grant0 && !port0.write) begin
                read_data0 <= ram_read_data;
            end
        end
    end

    // Client 1 read response: pulse valid and capture data on an accepted read.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            read_valid1 <= 1'b0;
            read_data1  <= '0;
        end else begin
            read_valid1 <= grant1 && !port1.write;
            if (grant1 && !port1.write) begin
                read_data1 <= ram_read_data;
            end
        end
    end

    assign port0.read_valid = read_valid0;
    assign port0.read_data  = read_data0;
    assign port1.read_valid = read_valid1;
    assign port1.read_data  = read_data1;

endmodule

// File: tb/tb_ram_single_port_arbiter.sv
// Self-checking bench for ram_single_port_arbiter: directed scenarios with literal
// expectations plus a randomized phase checked every cycle against a transaction model.
// Honours RAM_SINGLE_PORT_ARBITER_ROUND_ROBIN_EN for the expected arbitration.
module tb_ram_single_port_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic clock;
    logic resetn;

    logic            ram_we;
    logic            ram_re;
    logic [AW-1:0]   ram_addr;
    logic [WIDTH-1:0] ram_wd;
    logic [WIDTH-1:0] ram_rd;

    // Client drive values, indexed by client number.
    logic            v[2];
    logic            w[2];
    logic [AW-1:0]   a[2];
    logic [WIDTH-1:0] d[2];

    int errors = 0;
    int checks = 0;

    ram_single_port_arbiter_if #(.WIDTH(WIDTH), .ADDRESS_WIDTH(AW)) p0 ();
    ram_single_port_arbiter_if #(.WIDTH(WIDTH), .ADDRESS_WIDTH(AW)) p1 ();

    assign p0.valid      = v[0];
    assign p0.write      = w[0];
    assign p0.address    = a[0];
    assign p0.write_data = d[0];
    assign p1.valid      = v[1];
    assign p1.write      = w[1];
    assign p1.address    = a[1];
    assign p1.write_data = d[1];

    ram_single_port_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
        .clock            (clock),
        .resetn           (resetn),
        .port0            (p0),
        .port1            (p1),
        .ram_write_enable (ram_we),
        .ram_read_enable  (ram_re),
        .ram_address      (ram_addr),
        .ram_write_data   (ram_wd),
        .ram_read_data    (ram_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // The single-port RAM the arbiter drives: combinational read, write on the edge.
    logic [WIDTH-1:0] ram_mem[DEPTH];
    initial for (int i = 0; i < DEPTH; i++) ram_mem[i] = '0;
    assign ram_rd = ram_mem[ram_addr];
    always @(posedge clock) if (ram_we) ram_mem[ram_addr] <= ram_wd;

    // Transaction model: which client wins, and what each client should see next.
    logic [WIDTH-1:0] m_mem[DEPTH];
    logic             m_last;
    logic             m_rv[2];
    logic [WIDTH-1:0] m_rd[2];

    function automatic int exp_grant(logic v0, logic v1, logic last);
`ifdef RAM_SINGLE_PORT_ARBITER_ROUND_ROBIN_EN
        if (v0 && v1) return last ? 0 : 1;
`else
        if (v0 && v1) return 0;
`endif
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    initial begin
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        m_last = 1'b1;
        m_rv[0] = 1'b0; m_rv[1] = 1'b0;
        m_rd[0] = '0;   m_rd[1] = '0;
    end

    always @(posedge clock or negedge resetn) begin
        int g;
        if (!resetn) begin
            m_last = 1'b1;
            m_rv[0] = 1'b0; m_rv[1] = 1'b0;
            m_rd[0] = '0;   m_rd[1] = '0;
        end else begin
            g = exp_grant(v[0], v[1], m_last);
            m_rv[0] = 1'b0;
            m_rv[1] = 1'b0;
            if (g >= 0) begin
                if (w[g]) begin
                    m_mem[a[g]] = d[g];
                end else begin
                    m_rv[g] = 1'b1;
                    m_rd[g] = m_mem[a[g]];
                end
                m_last = (g == 1);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every cycle, mid-period: compare all DUT outputs against the model.
    always @(negedge clock) begin
        int g;
        g = exp_grant(v[0], v[1], m_last);
        check("ready0", p0.ready, g == 0);
        check("ready1", p1.ready, g == 1);
        check("ram_we", ram_we, (g >= 0) ? w[g] : 1'b0);
        check("ram_re", ram_re, (g >= 0) ? !w[g] : 1'b0);
        check("ram_addr", ram_addr, (g >= 0) ? a[g] : '0);
        check("ram_wd", ram_wd, (g >= 0) ? d[g] : '0);
        check("read_valid0", p0.read_valid, m_rv[0]);
        check("read_valid1", p1.read_valid, m_rv[1]);
        check("read_data0", p0.read_data, m_rd[0]);
        check("read_data1", p1.read_data, m_rd[1]);
    end

    task automatic drive(input int n, input logic val, input logic wr,
                         input logic [AW-1:0] adr, input logic [WIDTH-1:0] dat);
        v[n] = val; w[n] = wr; a[n] = adr; d[n] = dat;
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    initial begin
        logic pend[2];
        int   g;
        logic exp_r0;

        resetn = 1'b0;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) tick();
        check("reset rv0", p0.read_valid, 0);
        check("reset rd0", p0.read_data, 0);
        check("reset rv1", p1.read_valid, 0);
        check("reset rd1", p1.read_data, 0);
        resetn = 1'b1;

        // Write then read back through client 0.
        drive(0, 1, 1, 3, 8'hA5);
        #1 check("wr3 ready0", p0.ready, 1);
        tick();
        drive(0, 1, 0, 3, 0);
        #1 check("rd3 ready0", p0.ready, 1);
        tick();
        drive(0, 0, 0, 0, 0);
        check("rd3 rv0", p0.read_valid, 1);
        check("rd3 data", p0.read_data, 8'hA5);
        check("rd3 rv1", p1.read_valid, 0);

        // Client 1 writes, client 0 reads the same address immediately after.
        drive(1, 1, 1, 7, 8'h3C);
        #1 check("wr7 ready1", p1.ready, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        drive(0, 1, 0, 7, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("rd7 data", p0.read_data, 8'h3C);

        // Preload, ending on a client 1 transfer, then one idle cycle.
        drive(0, 1, 1, 1, 8'h11);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 1, 1, 2, 8'h22);
        tick();
        drive(1, 0, 0, 0, 0);
        #1;
        check("idle we", ram_we, 0);
        check("idle re", ram_re, 0);
        check("idle addr", ram_addr, 0);
        tick();
        check("idle rv0", p0.read_valid, 0);
        check("idle rv1", p1.read_valid, 0);

        // Continuous contention: alternates under round-robin, client 0 otherwise.
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 2, 0);
        for (int k = 0; k < 4; k++) begin
`ifdef RAM_SINGLE_PORT_ARBITER_ROUND_ROBIN_EN
            exp_r0 = (k % 2 == 0);
`else
            exp_r0 = 1'b1;
`endif
            #1;
            check("cont ready0", p0.ready, exp_r0);
            check("cont ready1", p1.ready, !exp_r0);
            tick();
            if (exp_r0) begin
                check("cont rv0", p0.read_valid, 1);
                check("cont rd0", p0.read_data, 8'h11);
            end else begin
                check("cont rv1", p1.read_valid, 1);
                check("cont rd1", p1.read_data, 8'h22);
            end
        end
        drive(0, 0, 0, 0, 0);
        #1 check("drop0 ready1", p1.ready, 1);
        tick();
        drive(1, 0, 0, 0, 0);
        check("drop0 rd1", p1.read_data, 8'h22);

        // Reset right after an accepted read: outputs clear without a clock edge.
        drive(0, 1, 0, 3, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        check("pre-reset rv0", p0.read_valid, 1);
        resetn = 1'b0;
        #1;
        check("async rv0", p0.read_valid, 0);
        check("async rd0", p0.read_data, 0);
        check("async rv1", p1.read_valid, 0);
        check("async rd1", p1.read_data, 0);
        tick();
        resetn = 1'b1;
        drive(0, 1, 0, 1, 0);
        drive(1, 1, 0, 2, 0);
        #1;
        check("post-reset ready0", p0.ready, 1);
        check("post-reset ready1", p1.ready, 0);
        tick();
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick();

        // Random traffic; a request that was not granted is held unchanged.
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        for (int c = 0; c < 500; c++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n]) begin
                    drive(n, ($urandom % 3) != 0, $urandom % 2, AW'($urandom % DEPTH),
                          WIDTH'($urandom % 256));
                end
            end
            g = exp_grant(v[0], v[1], m_last);
            pend[0] = v[0] && (g != 0);
            pend[1] = v[1] && (g != 1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
